// File: rtl/keypad_pkg.sv
// Shared key codes, entry FSM states and key classification for keypad consumers.
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] KEY_BKSP  = 4'hC;

  typedef enum logic [1:0] {
    EMPTY,
    ENTRY,
    DONE
  } entry_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/key_event_detect.sv
// Turns the scanner's key-present level into a one-cycle evt pulse per press,
// with the key code captured on that press.
module key_event_detect (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] code,
  input  logic       rd_enable,
  output logic       evt,
  output logic [3:0] evt_code
);

  logic       rd_q;
  logic [3:0] code_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_q   <= 1'b0;
      code_q <= '0;
    end else begin
      rd_q <= rd_enable;
      if (evt) code_q <= code;
    end
  end

  // evt is combinational so the consumer acts on the same edge that sees the press.
  always_comb begin
    evt      = rd_enable & ~rd_q;
    evt_code = evt ? code : code_q;
  end

endmodule

// File: rtl/keypad_bcd_entry.sv
// Multi-digit packed-BCD keypad entry with clear/backspace/enter and valid/ready output.
// Optional idle auto-clear and timeout_pulse output: define KEYPAD_ENTRY_TIMEOUT_EN.
module keypad_bcd_entry
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CNT_W          = $clog2(NUM_DIGITS + 1),
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [3:0]              code,
  input  logic                    rd_enable,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [CNT_W-1:0]        digit_count,
  output logic                    entry_valid,
  output logic                    overflow,
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  output logic                    timeout_pulse,
`endif
  output logic                    busy
);

  localparam int BCD_W = 4 * NUM_DIGITS;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("keypad_bcd_entry: unsupported parameter value");
  end

  entry_state_t     state_q, state_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             evt;
  logic [3:0]       evt_code;
  logic             timeout_hit;

  key_event_detect u_evt (
    .clock     (clock),
    .reset_n   (reset_n),
    .code      (code),
    .rd_enable (rd_enable),
    .evt       (evt),
    .evt_code  (evt_code)
  );

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] idle_q;
  logic            to_pulse_q;

  // A key event in the expiry cycle restarts the count rather than clearing.
  assign timeout_hit = (state_q == ENTRY) && !evt &&
                       (idle_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      idle_q     <= '0;
      to_pulse_q <= 1'b0;
    end else begin
      to_pulse_q <= timeout_hit;
      if (state_q != ENTRY || evt || timeout_hit) idle_q <= '0;
      else                                         idle_q <= idle_q + TO_W'(1);
    end
  end

  assign timeout_pulse = to_pulse_q;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      EMPTY: begin
        if (evt) begin
          if (is_digit(evt_code)) begin
            bcd_d   = (bcd_q << 4) | BCD_W'(evt_code);
            cnt_d   = CNT_W'(1);
            state_d = ENTRY;
          end else if (evt_code == KEY_CLEAR) begin
            ovf_d = 1'b0;
          end
        end
      end
      ENTRY: begin
        if (timeout_hit) begin
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = EMPTY;
        end else if (evt) begin
          if (is_digit(evt_code)) begin
            if (cnt_q < CNT_W'(NUM_DIGITS)) begin
              bcd_d = (bcd_q << 4) | BCD_W'(evt_code);
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end else if (evt_code == KEY_BKSP) begin
            bcd_d = bcd_q >> 4;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = EMPTY;
          end else if (evt_code == KEY_CLEAR) begin
            bcd_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = EMPTY;
          end else if (evt_code == KEY_ENTER) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Keys are ignored here; the transfer takes precedence over any press.
        if (out_ready) begin
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    bcd         = bcd_q;
    digit_count = cnt_q;
    overflow    = ovf_q;
    entry_valid = (state_q == DONE);
    busy        = (cnt_q != '0) || (state_q == DONE);
  end

endmodule
